// File: rtl/wb_pkg.sv
// Shared types for the write buffer: sequencer states, buffered entry layout
// and the word/byte address helper.
package wb_pkg;

  localparam int WB_DEPTH      = 4;
  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_PTR_W      = $clog2(WB_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RESP = 2'd3
  } wb_state_t;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-3:0] waddr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  function automatic logic [WB_ADDR_WIDTH-1:0] word_to_byte(input logic [WB_ADDR_WIDTH-3:0] waddr);
    return {waddr, 2'b00};
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular store of pending write-throughs with a combinational
// youngest-match lookup used to forward buffered data to cache reads.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WB_ADDR_WIDTH-3:0] push_waddr_i,
  input  logic [WB_DATA_WIDTH-1:0] push_data_i,
  input  logic                     pop_i,
  output logic [WB_ADDR_WIDTH-3:0] head_waddr_o,
  output logic [WB_DATA_WIDTH-1:0] head_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  input  logic [WB_ADDR_WIDTH-3:0] lookup_waddr_i,
  output logic                     hit_o,
  output logic [WB_DATA_WIDTH-1:0] hit_data_o
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_i) entries_q[tail_q] <= '{waddr: push_waddr_i, data: push_data_i};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_d  = head_q + PTR_W'(pop_i);
    tail_d  = tail_q + PTR_W'(push_i);
    count_d = count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
  end

  assign head_waddr_o = entries_q[head_q].waddr;
  assign head_data_o  = entries_q[head_q].data;
  assign full_o       = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (((PTR_W+1)'(k) < count_q) && (entries_q[idx].waddr == lookup_waddr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = entries_q[idx].data;
      end
    end
  end

endmodule

// File: rtl/write_buffer.sv
// Write-through buffer and memory sequencer between the data cache and data
// memory: stores complete into the FIFO, reads forward or go to memory.
module write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH      = WB_DEPTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    MemRead_wire,
  input  logic                    MemWrite_wire,
  input  logic [ADDR_WIDTH-1:0]   MemAddress_wire,
  input  logic [DATA_WIDTH-1:0]   MemWriteData_wire,
  output logic                    MemValid_wire,
  output logic [DATA_WIDTH-1:0]   Datamem_wire,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [1:0]              dbg_state_o,
  output logic [$clog2(DEPTH):0]  dbg_count_o
);

  // Handshakes: the cache holds MemRead/MemWrite until a one-cycle MemValid
  // pulse; memory sees mem_req held with stable fields until the cycle
  // mem_ready is high, which completes the transfer.
  wb_state_t             state_q, state_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  wr_req, rd_req, rd_hit, rd_miss, deq, push;
  logic                  fifo_full, fifo_empty, fifo_hit;
  logic [ADDR_WIDTH-3:0] head_waddr;
  logic [DATA_WIDTH-1:0] head_data, hit_data;
  logic                  byte_offset_unused;

  assign byte_offset_unused = ^MemAddress_wire[1:0];

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i          (clk),
    .rst_ni         (rst),
    .push_i         (push),
    .push_waddr_i   (MemAddress_wire[ADDR_WIDTH-1:2]),
    .push_data_i    (MemWriteData_wire),
    .pop_i          (deq),
    .head_waddr_o   (head_waddr),
    .head_data_o    (head_data),
    .full_o         (fifo_full),
    .empty_o        (fifo_empty),
    .count_o        (dbg_count_o),
    .lookup_waddr_i (MemAddress_wire[ADDR_WIDTH-3+2:2]),
    .hit_o          (fifo_hit),
    .hit_data_o     (hit_data)
  );

  // Requests sampled during a MemValid pulse belong to the one just served.
  always_comb begin
    wr_req  = MemWrite_wire && !valid_q;
    rd_req  = MemRead_wire && !MemWrite_wire && !valid_q;
    rd_hit  = rd_req && fifo_hit;
    rd_miss = rd_req && !fifo_hit;
    deq     = (state_q == ST_WR) && mem_ready;
    push    = wr_req && (!fifo_full || deq);
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = push || rd_hit;
    rdata_d     = rd_hit ? hit_data : rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_miss) begin
          state_d    = ST_RD;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = word_to_byte(MemAddress_wire[ADDR_WIDTH-1:2]);
        end else if (!fifo_empty) begin
          state_d     = ST_WR;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = word_to_byte(head_waddr);
          mem_wdata_d = head_data;
        end
      end
      ST_WR: begin
        if (mem_ready) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end
      ST_RD: begin
        if (mem_ready) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          valid_d   = 1'b1;
          rdata_d   = mem_rdata;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign MemValid_wire = valid_q;
  assign Datamem_wire  = rdata_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: cache-side steps with hand-computed
// expectations and an ordered queue of memory writes expected to drain.
module tb_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_wire, MemWrite_wire;
  logic [31:0] MemAddress_wire, MemWriteData_wire;
  logic        MemValid_wire;
  logic [31:0] Datamem_wire;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_count;

  int          checks   = 0;
  int          failures = 0;
  logic        auto_ready = 1'b0;
  logic [63:0] exp_q[$];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // clock / reset
  always #5 clk = ~clk;

  write_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .MemRead_wire      (MemRead_wire),
    .MemWrite_wire     (MemWrite_wire),
    .MemAddress_wire   (MemAddress_wire),
    .MemWriteData_wire (MemWriteData_wire),
    .MemValid_wire     (MemValid_wire),
    .Datamem_wire      (Datamem_wire),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_ready         (mem_ready),
    .mem_rdata         (mem_rdata),
    .dbg_state_o       (dbg_state),
    .dbg_count_o       (dbg_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score a memory write completing at this edge, then advance.
  task automatic tick();
    logic [63:0] e;
    if (mem_req && mem_we && mem_ready) begin
      check("mem_wr_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mem_wr", {mem_addr, mem_wdata}, e);
      end
    end
    @(posedge clk);
    #1;
    if (auto_ready) mem_ready = mem_req;
  endtask

  // Driver: write accepted on the first edge, pulse next cycle, then a gap.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    MemWrite_wire     = 1'b1;
    MemAddress_wire   = a;
    MemWriteData_wire = d;
    tick();
    check("wr_pulse", MemValid_wire, 1);
    MemWrite_wire = 1'b0;
    exp_q.push_back({a[31:2], 2'b00, d});
    tick();
    check("wr_pulse_single", MemValid_wire, 0);
  endtask

  task automatic drain(input string tag);
    auto_ready = 1'b1;
    mem_ready  = mem_req;
    for (int i = 0; i < 40; i++) begin
      if (dbg_count == 3'd0 && !mem_req && dbg_state == S_IDLE) break;
      tick();
    end
    auto_ready = 1'b0;
    mem_ready  = 1'b0;
    check(tag, {dbg_count, mem_req}, {3'd0, 1'b0});
  endtask

  initial begin
    rst = 1'b0;
    MemRead_wire = 1'b0; MemWrite_wire = 1'b0;
    MemAddress_wire = '0; MemWriteData_wire = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("rst_valid", MemValid_wire, 0);
    check("rst_datamem", Datamem_wire, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_count", dbg_count, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst = 1'b1;
    tick();

    // Reset while a drain is waiting on memory.
    do_write(32'h100, 32'h11);
    check("drain_req", {mem_req, mem_we, dbg_state}, {1'b1, 1'b1, S_WR});
    check("drain_addr", mem_addr, 32'h100);
    check("drain_wdata", mem_wdata, 32'h11);
    tick();
    check("drain_hold_req", mem_req, 1);
    check("drain_hold_addr", mem_addr, 32'h100);
    rst = 1'b0;
    #1;
    check("rst_async_req", mem_req, 0);
    check("rst_async_we", mem_we, 0);
    check("rst_async_addr", mem_addr, 0);
    check("rst_async_wdata", mem_wdata, 0);
    check("rst_async_count", dbg_count, 0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_no_pulse", MemValid_wire, 0);
      check("post_rst_no_req", mem_req, 0);
    end
    check("post_rst_count", dbg_count, 0);

    // Fill with memory stalled, then a fifth write stalls until a dequeue.
    do_write(32'h00, 32'hA0);
    do_write(32'h04, 32'hA1);
    do_write(32'h08, 32'hA2);
    do_write(32'h0C, 32'hA3);
    check("full_count", dbg_count, 4);
    check("full_head_addr", mem_addr, 32'h00);
    check("full_head_wdata", mem_wdata, 32'hA0);
    MemWrite_wire = 1'b1; MemAddress_wire = 32'h40; MemWriteData_wire = 32'h44;
    tick();
    check("stall_no_pulse", MemValid_wire, 0);
    tick();
    check("stall_no_pulse2", MemValid_wire, 0);
    check("stall_count", dbg_count, 4);
    mem_ready = 1'b1;
    tick();
    exp_q.push_back({32'h40, 32'h44});
    check("deq_accept_pulse", MemValid_wire, 1);
    check("deq_accept_count", dbg_count, 4);
    check("deq_req_drop", mem_req, 0);
    MemWrite_wire = 1'b0; mem_ready = 1'b0;
    tick();
    drain("drain_full");

    // Forwarding: youngest of two aliasing entries, no memory read.
    do_write(32'h10, 32'hAAAA);
    do_write(32'h10, 32'hBBBB);
    MemRead_wire = 1'b1; MemAddress_wire = 32'h12;
    tick();
    check("hit_pulse", MemValid_wire, 1);
    check("hit_data", Datamem_wire, 32'hBBBB);
    check("hit_no_mem_read", mem_req && !mem_we, 0);
    check("hit_count", dbg_count, 2);
    MemRead_wire = 1'b0;
    tick();
    check("hit_no_mem_read2", mem_req && !mem_we, 0);

    // Read miss waits for the in-flight write, then beats the queued one.
    MemRead_wire = 1'b1; MemAddress_wire = 32'h80;
    tick();
    check("miss_wait_valid", MemValid_wire, 0);
    check("miss_wait_we", mem_we, 1);
    check("miss_wait_addr", mem_addr, 32'h10);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("miss_wr_done", {mem_req, dbg_state}, {1'b0, S_IDLE});
    check("miss_wr_count", dbg_count, 1);
    tick();
    check("miss_rd_issue", {mem_req, mem_we, dbg_state}, {1'b1, 1'b0, S_RD});
    check("miss_rd_addr", mem_addr, 32'h80);
    tick();
    check("miss_rd_hold", {mem_req, mem_we, MemValid_wire}, {1'b1, 1'b0, 1'b0});
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ready = 1'b0;
    check("miss_valid", MemValid_wire, 1);
    check("miss_data", Datamem_wire, 32'hDEADBEEF);
    check("miss_resp", {mem_req, dbg_state}, {1'b0, S_RESP});
    MemRead_wire = 1'b0;
    tick();
    check("miss_after_resp", {MemValid_wire, mem_req}, {1'b0, 1'b0});
    tick();
    check("queued_wr_issue", {mem_req, mem_we}, {1'b1, 1'b1});
    check("queued_wr_addr", mem_addr, 32'h10);
    check("queued_wr_data", mem_wdata, 32'hBBBB);
    drain("drain_after_miss");

    // Request held through its own pulse is serviced once.
    MemWrite_wire = 1'b1; MemAddress_wire = 32'h200; MemWriteData_wire = 32'h55;
    tick();
    check("held_pulse", MemValid_wire, 1);
    check("held_count", dbg_count, 1);
    tick();
    MemWrite_wire = 1'b0;
    exp_q.push_back({32'h200, 32'h55});
    check("held_no_second_pulse", MemValid_wire, 0);
    check("held_single_enqueue", dbg_count, 1);
    drain("drain_held");

    // Fill / drain / refill across pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++)
        do_write(32'h300 + 32'(16*r) + 32'(4*i), 32'hC000 + 32'(4*r + i));
      check("refill_full", dbg_count, 4);
      drain("refill_drain");
    end

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
